csr_irq_unit: RTL and testbench
===============================

Name: csr_irq_unit

Overview:
Parametrised machine-mode CSR and interrupt unit for the 5-stage RV32 core. It replaces the fixed two-source CSR block with N level-sensitive interrupt sources, a fixed-priority arbiter, mie/mip masking, WFI sleep/wake, mret and 64-bit cycle/instret counters. It sits beside the decode stage, supplies trap and mret redirect targets to PC, and supplies CSR read data to EX.

Parameters:
N_IRQ, 2, number of interrupt sources (1..16); index 0 is highest priority.
MTVEC_VAL, 32'h0001_0000, fixed trap vector; the mtvec CSR is read-only.
IRQ_CAUSE_BASE, 16, mcause code for irq[0]; source i reports BASE+i with bit31 set.
CNT_W, 64, width of mcycle and minstret (32 or 64).

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
busStall  in  2  any bit set freezes all architectural updates except mcycle and mip sampling
irq  in  N_IRQ  level-sensitive interrupt requests
csr_valid  in  1  CSR instruction present in ID
csr_op  in  3  funct3 (RW/RS/RC, register or immediate form)
csr_addr  in  12  CSR address
csr_wdata  in  32  operand (rs1 value or zimm, selected upstream)
csr_rdata  out  32  old CSR value, combinational
is_mret  in  1  mret in ID
is_wfi  in  1  wfi in ID
pc_ID  in  32  PC of the instruction in ID
retire  in  1  one instruction retired this cycle
trap_take  out  1  redirect to MTVEC_VAL and flush IF/ID
mret_take  out  1  redirect to mepc
mepc  out  32  current mepc
wfi_sleep  out  1  hold fetch while asleep

Behaviour:
- Reset values: mstatus.MIE=0, MPIE=0, MPP reads 2'b11; mie=0; mepc=0; mcause=0; counters=0; state=RUN; all outputs 0 except csr_rdata, which decodes the reset state.
- Addresses: mstatus 0x300, mie 0x304, mtvec 0x305 (RO), mepc 0x341, mcause 0x342, mip 0x344 (RO), mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82. Unmapped addresses read 0, and writes to them are ignored. Writes to RO addresses are ignored. mie bits at N_IRQ and above read 0.
- Writes: op[1:0]=01 RW, 10 set, 11 clear. For set/clear, csr_wdata==0 means no write. Writes take effect at the clock edge and are visible to the next instruction. Writes are suppressed when busStall!=0 or trap_take=1.
- mip[i]=irq[i] sampled every cycle. pending = mip & mie. Winner = lowest set index.
- trap_take = mstatus.MIE & |pending & (busStall==0). This is a combinational pulse.
- On trap: mepc <= pc_ID, or pc_ID+4 when waking from SLEEP. mcause <= {1'b1, BASE+idx}. MPIE <= MIE. MIE <= 0.
- mret_take = is_mret & ~trap_take & (busStall==0). On mret: MIE <= MPIE, MPIE <= 1.
- Trap has priority over a simultaneous mret or CSR write. The suppressed instruction is replayed after the handler returns.
- FSM RUN->SLEEP when is_wfi & ~trap_take & busStall==0. While in SLEEP, wfi_sleep=1.
- SLEEP exits when |pending, regardless of MIE. If MIE=1, it exits through trap_take with mepc=pc_ID+4. If MIE=0, it returns to RUN with no trap and fetch resumes at pc_ID+4.
- mcycle increments every cycle, including during stall and sleep. minstret increments on retire & busStall==0. Both wrap modulo 2^CNT_W.
- A CSR write to a counter in the same cycle overrides that cycle's increment. Writes to the low half leave the high half unchanged. With CNT_W=32, mcycleh and minstreth read 0.
- Reset mid-sleep or mid-trap returns to RUN with reset values immediately.

Optional Feature:
IRQ_SYNC_EN. When defined, each irq bit passes through a 2-flop synchronizer (reset 0) before mip, adding 2 cycles of latency from irq to trap_take. When undefined, mip samples irq directly and trap_take can assert in the same cycle irq rises.

Decomposition:
- Package csr_pkg holds: CSR address localparams; a csr_op enum (RW, RS, RC); an FSM state enum {RUN, SLEEP}; and mstatus bit-position constants (MIE=3, MPIE=7).
- Sub-module irq_prio_enc: a parametrised N_IRQ fixed-priority encoder producing a valid flag and a $clog2(N_IRQ)-bit index.

Test Plan:
- Reset, then read 0x305, 0x300, 0x344 -> 32'h0001_0000, 32'h0000_1800, 0.
- mie=3, MIE=1, irq=2'b11 with pc_ID=0x120 -> trap_take=1 for one cycle; mepc=0x120; mcause=0x8000_0010; MIE=0; MPIE=1.
- Run mret after that trap -> mret_take=1; mepc output=0x120; MIE=1.
- MIE=0, mie[1]=1, wfi at 0x200 -> wfi_sleep=1 until irq[1] rises; then return to RUN with no trap. Repeat with MIE=1 -> trap with mepc=0x204.
- busStall=2'b01 during csrrw 0x341 and with irq pending -> no write and no trap; mcycle still increments. Release stall -> write or trap occurs.
- Write mcycle=32'hFFFF_FFFF with mcycleh=0, wait one cycle -> mcycleh=1, mcycle=0. The same write together with a retire -> the written value wins.

Source files
------------

// File: rtl/csr_irq_unit_pkg.sv
// Shared constants and types for the machine-mode CSR / interrupt unit (package csr_pkg).
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_RW = 2'b01,
        CSR_RS = 2'b10,
        CSR_RC = 2'b11
    } csr_op_e;

    typedef enum logic {
        RUN   = 1'b0,
        SLEEP = 1'b1
    } state_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    // MPP is hardwired to machine mode
    localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csr_irq_unit_irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
    parameter int N_IRQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_IRQ-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file with N-source interrupt arbitration, WFI sleep, mret and counters.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer on every irq input.
module csr_irq_unit
    import csr_pkg::*;
#(
    parameter int          N_IRQ          = 2,
    parameter logic [31:0] MTVEC_VAL      = 32'h0001_0000,
    parameter int          IRQ_CAUSE_BASE = 16,
    parameter int          CNT_W          = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       busStall,
    input  logic [N_IRQ-1:0] irq,
    input  logic             csr_valid,
    input  logic [2:0]       csr_op,
    input  logic [11:0]      csr_addr,
    input  logic [31:0]      csr_wdata,
    output logic [31:0]      csr_rdata,
    input  logic             is_mret,
    input  logic             is_wfi,
    input  logic [31:0]      pc_ID,
    input  logic             retire,
    output logic             trap_take,
    output logic             mret_take,
    output logic [31:0]      mepc,
    output logic             wfi_sleep
);

    localparam int IDX_W = idx_width(N_IRQ);

    state_e           state;
    logic             glb_ie;
    logic             prev_ie;
    logic [N_IRQ-1:0] irq_en;
    logic [N_IRQ-1:0] mip;
    logic [31:0]      mcause;
    logic [CNT_W-1:0] mcycle;
    logic [CNT_W-1:0] minstret;
    logic [63:0]      cyc64;
    logic [63:0]      ins64;
    logic             stall;
    logic             pend_valid;
    logic [IDX_W-1:0] pend_idx;
    logic [30:0]      cause_code;
    logic [1:0]       op;
    logic [31:0]      wnew;
    logic             csr_we;
    logic             unused_op_imm;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] irq_s1;
    logic [N_IRQ-1:0] irq_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
        end else begin
            irq_s1 <= irq;
            irq_s2 <= irq_s1;
        end
    end
    assign mip = irq_s2;
`else
    assign mip = irq;
`endif

    irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req   (mip & irq_en),
        .valid (pend_valid),
        .idx   (pend_idx)
    );

    assign stall         = |busStall;
    assign trap_take     = glb_ie & pend_valid & ~stall;
    assign mret_take     = is_mret & ~trap_take & ~stall;
    assign wfi_sleep     = (state == SLEEP);
    assign cause_code    = 31'(IRQ_CAUSE_BASE) + 31'(pend_idx);
    assign op            = csr_op[1:0];
    assign unused_op_imm = csr_op[2];
    assign cyc64         = 64'(mcycle);
    assign ins64         = 64'(minstret);

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata               = MSTATUS_MPP_M;
                csr_rdata[MSTATUS_MIE]  = glb_ie;
                csr_rdata[MSTATUS_MPIE] = prev_ie;
            end
            CSR_MIE:       csr_rdata = 32'(irq_en);
            CSR_MTVEC:     csr_rdata = MTVEC_VAL;
            CSR_MEPC:      csr_rdata = mepc;
            CSR_MCAUSE:    csr_rdata = mcause;
            CSR_MIP:       csr_rdata = 32'(mip);
            CSR_MCYCLE:    csr_rdata = cyc64[31:0];
            CSR_MCYCLEH:   csr_rdata = cyc64[63:32];
            CSR_MINSTRET:  csr_rdata = ins64[31:0];
            CSR_MINSTRETH: csr_rdata = ins64[63:32];
            default:       csr_rdata = '0;
        endcase
    end

    // Set/clear with a zero operand is a pure read and must not write
    always_comb begin
        case (op)
            CSR_RW:  wnew = csr_wdata;
            CSR_RS:  wnew = csr_rdata | csr_wdata;
            CSR_RC:  wnew = csr_rdata & ~csr_wdata;
            default: wnew = csr_rdata;
        endcase
        csr_we = csr_valid & (op != 2'b00) & ~stall & ~trap_take
               & ((op == CSR_RW) | (csr_wdata != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            glb_ie  <= 1'b0;
            prev_ie <= 1'b0;
            irq_en  <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else begin
            case (state)
                RUN:     if (is_wfi && !trap_take && !stall) state <= SLEEP;
                SLEEP:   if (pend_valid && !stall) state <= RUN;
                default: state <= RUN;
            endcase
            if (trap_take) begin
                mepc    <= (state == SLEEP) ? pc_ID + 32'd4 : pc_ID;
                mcause  <= {1'b1, cause_code};
                prev_ie <= glb_ie;
                glb_ie  <= 1'b0;
            end else if (mret_take) begin
                glb_ie  <= prev_ie;
                prev_ie <= 1'b1;
            end
            if (csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        glb_ie  <= wnew[MSTATUS_MIE];
                        prev_ie <= wnew[MSTATUS_MPIE];
                    end
                    CSR_MIE:    irq_en <= wnew[N_IRQ-1:0];
                    CSR_MEPC:   mepc   <= wnew;
                    CSR_MCAUSE: mcause <= wnew;
                    default: ;
                endcase
            end
        end
    end

    // A counter write replaces that cycle's increment; the other half is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_we && csr_addr == CSR_MCYCLE)
                mcycle <= CNT_W'({cyc64[63:32], wnew});
            else if (csr_we && csr_addr == CSR_MCYCLEH && CNT_W > 32)
                mcycle <= CNT_W'({wnew, cyc64[31:0]});
            else
                mcycle <= mcycle + CNT_W'(1);

            if (csr_we && csr_addr == CSR_MINSTRET)
                minstret <= CNT_W'({ins64[63:32], wnew});
            else if (csr_we && csr_addr == CSR_MINSTRETH && CNT_W > 32)
                minstret <= CNT_W'({wnew, ins64[31:0]});
            else if (retire && !stall)
                minstret <= minstret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_csr_irq_unit.sv
// Directed scoreboard bench for csr_irq_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_csr_irq_unit;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  busStall;
    logic [1:0]  irq;
    logic        csr_valid;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        is_mret;
    logic        is_wfi;
    logic [31:0] pc_ID;
    logic        retire;
    logic        trap_take;
    logic        mret_take;
    logic [31:0] mepc;
    logic        wfi_sleep;

    csr_irq_unit dut (
        .clk       (clk),
        .rst       (rst),
        .busStall  (busStall),
        .irq       (irq),
        .csr_valid (csr_valid),
        .csr_op    (csr_op),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .is_mret   (is_mret),
        .is_wfi    (is_wfi),
        .pc_ID     (pc_ID),
        .retire    (retire),
        .trap_take (trap_take),
        .mret_take (mret_take),
        .mepc      (mepc),
        .wfi_sleep (wfi_sleep)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk_rd;
        logic [31:0] rd;
        logic        tt;
        logic        mt;
        logic        ws;
        logic        chk_mepc;
        logic [31:0] mepc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    exp_t  mon_e;
    string mon_nm;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s got 0x%08h expected 0x%08h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            cmp(mon_nm, "trap_take", 32'(trap_take), 32'(mon_e.tt));
            cmp(mon_nm, "mret_take", 32'(mret_take), 32'(mon_e.mt));
            cmp(mon_nm, "wfi_sleep", 32'(wfi_sleep), 32'(mon_e.ws));
            if (mon_e.chk_rd)   cmp(mon_nm, "csr_rdata", csr_rdata, mon_e.rd);
            if (mon_e.chk_mepc) cmp(mon_nm, "mepc", mepc, mon_e.mepc);
        end else if (trap_take || mret_take) begin
            cmp("idle", "unexpected_redirect", {30'd0, trap_take, mret_take}, 32'd0);
        end
    end

    // Queue the expectation for the cycle just set up, then advance one clock
    task automatic stim(input string nm, input bit crd, input logic [31:0] rd,
                        input bit tt, input bit mt, input bit ws,
                        input bit cm, input logic [31:0] me);
        exp_t e;
        e.chk_rd   = crd;
        e.rd       = rd;
        e.tt       = tt;
        e.mt       = mt;
        e.ws       = ws;
        e.chk_mepc = cm;
        e.mepc     = me;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        csr_valid = 1'b0;
        csr_op    = 3'b000;
        is_mret   = 1'b0;
        is_wfi    = 1'b0;
        retire    = 1'b0;
    endtask

    task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = d;
    endtask

    task automatic rd(input logic [11:0] a);
        csr_addr = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; busStall = 2'b00; irq = 2'b00; csr_valid = 1'b0; csr_op = 3'b000;
        csr_addr = 12'h000; csr_wdata = 32'd0; is_mret = 1'b0; is_wfi = 1'b0;
        pc_ID = 32'd0; retire = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state and read-only decode
        rd(A_MSTATUS);                  stim("rst_mstatus", 1, 32'h0000_1800, 0, 0, 0, 1, 32'd0);
        rst = 1'b0;
        rd(A_MTVEC);                    stim("mtvec",       1, 32'h0001_0000, 0, 0, 0, 1, 32'd0);
        rd(A_MSTATUS);                  stim("mstatus0",    1, 32'h0000_1800, 0, 0, 0, 0, 32'd0);
        rd(A_MIP);                      stim("mip0",        1, 32'd0,         0, 0, 0, 0, 32'd0);

        // first trap: both sources pending, index 0 wins, beats a same-cycle mepc write
        csr(3'b001, A_MIE, 32'd3);      stim("wr_mie",      1, 32'd0,         0, 0, 0, 0, 32'd0);
        csr(3'b010, A_MSTATUS, 32'd8);  stim("set_mie",     1, 32'h0000_1800, 0, 0, 0, 0, 32'd0);
        irq = 2'b11; pc_ID = 32'h120;
        csr(3'b001, A_MEPC, 32'h999);   stim("trap0",       1, 32'd0,         1, 0, 0, 1, 32'd0);
        irq = 2'b00;
        rd(A_MEPC);                     stim("mepc_trap0",  1, 32'h120,       0, 0, 0, 1, 32'h120);
        rd(A_MCAUSE);                   stim("mcause0",     1, 32'h8000_0010, 0, 0, 0, 0, 32'd0);
        rd(A_MSTATUS);                  stim("mst_trap0",   1, 32'h0000_1880, 0, 0, 0, 0, 32'd0);
        is_mret = 1'b1; rd(A_MSTATUS);  stim("mret0",       1, 32'h0000_1880, 0, 1, 0, 1, 32'h120);
        rd(A_MSTATUS);                  stim("mst_mret0",   1, 32'h0000_1888, 0, 0, 0, 0, 32'd0);

        // WFI with MIE=0: masked source keeps sleeping, enabled source wakes without trap
        csr(3'b111, A_MSTATUS, 32'd8);  stim("clr_mie",     1, 32'h0000_1888, 0, 0, 0, 0, 32'd0);
        csr(3'b001, A_MIE, 32'd2);      stim("mie_irq1",    1, 32'd3,         0, 0, 0, 0, 32'd0);
        pc_ID = 32'h200; is_wfi = 1'b1;
        rd(A_MSTATUS);                  stim("wfi0",        1, 32'h0000_1880, 0, 0, 0, 0, 32'd0);
        irq = 2'b01; rd(A_MIP);         stim("sleep_mask",  1, 32'd1,         0, 0, 1, 0, 32'd0);
                                        stim("sleep_hold",  0, 32'd0,         0, 0, 1, 0, 32'd0);
        irq = 2'b10;                    stim("wake_nomie",  0, 32'd0,         0, 0, 1, 1, 32'h120);
        irq = 2'b00;                    stim("run_wake",    0, 32'd0,         0, 0, 0, 1, 32'h120);

        // WFI with MIE=1: wake through trap, mepc points past the wfi
        csr(3'b010, A_MSTATUS, 32'd8);  stim("set_mie2",    1, 32'h0000_1880, 0, 0, 0, 0, 32'd0);
        is_wfi = 1'b1; rd(A_MSTATUS);   stim("wfi1",        1, 32'h0000_1888, 0, 0, 0, 0, 32'd0);
                                        stim("sleep1",      0, 32'd0,         0, 0, 1, 0, 32'd0);
        irq = 2'b10;                    stim("wake_trap",   0, 32'd0,         1, 0, 1, 1, 32'h120);
        irq = 2'b00; rd(A_MCAUSE);      stim("mcause1",     1, 32'h8000_0011, 0, 0, 0, 1, 32'h204);
        rd(A_MSTATUS);                  stim("mst_trap1",   1, 32'h0000_1880, 0, 0, 0, 0, 32'd0);

        // stall freezes writes and traps but not mcycle
        csr(3'b010, A_MSTATUS, 32'd8);  stim("set_mie3",    1, 32'h0000_1880, 0, 0, 0, 0, 32'd0);
        csr(3'b001, A_MCYCLEH, 32'd0);  stim("cyc_h_pre",   0, 32'd0,         0, 0, 0, 0, 32'd0);
        csr(3'b001, A_MCYCLE, 32'h1000); stim("cyc_l_pre",  0, 32'd0,         0, 0, 0, 0, 32'd0);
        busStall = 2'b01; irq = 2'b10; pc_ID = 32'h300;
        csr(3'b001, A_MEPC, 32'h5550);  stim("stall_wr",    1, 32'h204,       0, 0, 0, 1, 32'h204);
        csr(3'b001, A_MCYCLE, 32'h7777); stim("stall_cyc",  1, 32'h1001,      0, 0, 0, 1, 32'h204);
        rd(A_MCYCLE);                   stim("stall_inc",   1, 32'h1002,      0, 0, 0, 1, 32'h204);
        busStall = 2'b00;
        csr(3'b001, A_MEPC, 32'h5550);  stim("unstall_trap", 1, 32'h204,      1, 0, 0, 1, 32'h204);
        irq = 2'b00;
        csr(3'b001, A_MEPC, 32'h5550);  stim("unstall_wr",  1, 32'h300,       0, 0, 0, 1, 32'h300);
        rd(A_MEPC);                     stim("mepc_wr",     1, 32'h5550,      0, 0, 0, 1, 32'h5550);
        busStall = 2'b10; is_mret = 1'b1; stim("stall_mret", 0, 32'd0,       0, 0, 0, 0, 32'd0);
        busStall = 2'b00; is_mret = 1'b1; stim("mret1",     0, 32'd0,         0, 1, 0, 1, 32'h5550);
        rd(A_MSTATUS);                  stim("mst_mret1",   1, 32'h0000_1888, 0, 0, 0, 0, 32'd0);

        // 64-bit counter carry and write-over-increment
        csr(3'b001, A_MCYCLEH, 32'd0);  stim("cyc_h0",      0, 32'd0,         0, 0, 0, 0, 32'd0);
        csr(3'b001, A_MCYCLE, 32'hFFFF_FFFF); stim("cyc_lo", 0, 32'd0,        0, 0, 0, 0, 32'd0);
                                        stim("cyc_wait",    0, 32'd0,         0, 0, 0, 0, 32'd0);
        rd(A_MCYCLE);                   stim("cyc_wrap_lo", 1, 32'd0,         0, 0, 0, 0, 32'd0);
        rd(A_MCYCLEH);                  stim("cyc_wrap_hi", 1, 32'd1,         0, 0, 0, 0, 32'd0);
        csr(3'b001, A_MINSTRETH, 32'd0); stim("ins_h0",     0, 32'd0,         0, 0, 0, 0, 32'd0);
        csr(3'b001, A_MINSTRET, 32'hFFFF_FFFF); retire = 1'b1;
                                        stim("ins_wr_ret",  0, 32'd0,         0, 0, 0, 0, 32'd0);
        rd(A_MINSTRET);                 stim("ins_wins",    1, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'd0);
        rd(A_MINSTRET); retire = 1'b1;  stim("ins_ret",     1, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'd0);
        rd(A_MINSTRET);                 stim("ins_wrap_lo", 1, 32'd0,         0, 0, 0, 0, 32'd0);
        rd(A_MINSTRETH);                stim("ins_wrap_hi", 1, 32'd1,         0, 0, 0, 0, 32'd0);
        busStall = 2'b01; retire = 1'b1;
        rd(A_MINSTRET);                 stim("ins_stall",   1, 32'd0,         0, 0, 0, 0, 32'd0);
        busStall = 2'b00;
        rd(A_MINSTRET);                 stim("ins_held",    1, 32'd0,         0, 0, 0, 0, 32'd0);

        // unmapped, read-only and masked-width writes
        csr(3'b001, 12'h123, 32'd5);    stim("unmapped",    1, 32'd0,         0, 0, 0, 0, 32'd0);
        csr(3'b001, A_MTVEC, 32'd0);    stim("mtvec_wr",    1, 32'h0001_0000, 0, 0, 0, 0, 32'd0);
        rd(A_MTVEC);                    stim("mtvec_ro",    1, 32'h0001_0000, 0, 0, 0, 0, 32'd0);
        csr(3'b001, A_MIE, 32'hFFFF);   stim("mie_wide",    1, 32'd2,         0, 0, 0, 0, 32'd0);
        csr(3'b011, A_MIE, 32'd0);      stim("rc_zero",     1, 32'd3,         0, 0, 0, 0, 32'd0);
        rd(A_MIE);                      stim("mie_kept",    1, 32'd3,         0, 0, 0, 0, 32'd0);

        // reset while asleep
        pc_ID = 32'h400; is_wfi = 1'b1; stim("wfi2",        0, 32'd0,         0, 0, 0, 0, 32'd0);
                                        stim("sleep2",      0, 32'd0,         0, 0, 1, 1, 32'h5550);
        rst = 1'b1; rd(A_MSTATUS);      stim("rst_sleep",   1, 32'h0000_1800, 0, 0, 0, 1, 32'd0);
        rst = 1'b0; rd(A_MIE);          stim("rst_mie",     1, 32'd0,         0, 0, 0, 0, 32'd0);
        rd(A_MCAUSE);                   stim("rst_mcause",  1, 32'd0,         0, 0, 0, 0, 32'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
